fifo_write_arbiter: RTL and testbench

- Round-robin, burst-capable arbiter that shares the async FIFO write port between NUM_REQ requesters.
- Sits entirely in the write clock domain; drives the FIFO's w_en/data_in and obeys its full flag.
- Each requester uses a valid/ready handshake. A granted requester may hold the port for up to BURST_LEN consecutive beats before fairness rotation.

---
 rtl/fifo_write_arbiter.sv | 160 ++++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-capable arbiter sharing one FIFO write port among NUM_REQ requesters.
// Optional per-requester beat statistics are enabled with the FIFO_ARB_STATS_EN macro.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                            wclk,
    input  logic                            wrst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            full,
    output logic                            w_en,
    output logic [DATA_WIDTH-1:0]           data_in,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy,
    input  logic                            stat_clr,
    output logic [NUM_REQ*16-1:0]           stat_cnt
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic {ARB, OWN} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [7:0]       beat_cnt_q, beat_cnt_d;
    logic [IDW-1:0]   cand;
    logic             cand_found;
    logic [NUM_REQ-1:0] valid_g;
    logic [NUM_REQ-1:0] xfer;
    int               idx;

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        return (32'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // Requests are masked during reset so every combinational output settles to zero.
    assign valid_g = req_valid & {NUM_REQ{~wrst}};

    always_comb begin
        cand       = '0;
        cand_found = 1'b0;
        idx        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!cand_found && valid_g[idx]) begin
                cand       = IDW'(idx);
                cand_found = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready  = '0;
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ARB: begin
                if (cand_found && !full) begin
                    req_ready[cand] = 1'b1;
                    if (BURST_LEN == 1) begin
                        rr_ptr_d = next_idx(cand);
                    end else begin
                        owner_d    = cand;
                        beat_cnt_d = 8'd1;
                        state_d    = OWN;
                    end
                end
            end
            OWN: begin
                req_ready[owner_q] = ~full;
                // A dropped valid releases the lock after one bubble cycle.
                if (!valid_g[owner_q]) begin
                    state_d    = ARB;
                    rr_ptr_d   = next_idx(owner_q);
                    beat_cnt_d = '0;
                end else if (!full) begin
                    if (beat_cnt_q + 8'd1 == 8'(BURST_LEN)) begin
                        state_d    = ARB;
                        rr_ptr_d   = next_idx(owner_q);
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign xfer = valid_g & req_ready;
    assign w_en = |xfer;
    assign busy = (state_q == OWN);

    always_comb begin
        data_in  = '0;
        grant_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (xfer[i]) begin
                data_in  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                grant_id = IDW'(i);
            end
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q    <= ARB;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] stat_q [NUM_REQ];
    logic [15:0] stat_d [NUM_REQ];

    // Clear wins over a same-cycle increment; counters saturate at all-ones.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_d[i] = stat_q[i];
            if (stat_clr) begin
                stat_d[i] = '0;
            end else if (xfer[i] && stat_q[i] != 16'hFFFF) begin
                stat_d[i] = stat_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= stat_d[i];
        end
    end

    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) stat_cnt[i*16 +: 16] = stat_q[i];
    end
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: a 4-requester burst instance under random traffic
// and a 3-requester per-beat instance checking non-power-of-two round-robin wrap.
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int BL = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            wrst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            full = 1'b0;
    logic            w_en;
    logic [DW-1:0]   data_in;
    logic [1:0]      grant_id;
    logic            busy;
    logic            stat_clr = 1'b0;
    logic [N*16-1:0] stat_cnt;

    logic [2:0]      req_valid2 = 3'b111;
    logic [23:0]     req_data2 = 24'hCC_BB_AA;
    logic [2:0]      req_ready2;
    logic            w_en2;
    logic [7:0]      data_in2;
    logic [1:0]      grant_id2;
    logic            busy2;
    logic [47:0]     stat_cnt2;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .wclk(clk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .full(full), .w_en(w_en), .data_in(data_in),
        .grant_id(grant_id), .busy(busy), .stat_clr(stat_clr), .stat_cnt(stat_cnt)
    );

    fifo_write_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .BURST_LEN(1)) dut3 (
        .wclk(clk), .wrst(wrst), .req_valid(req_valid2), .req_data(req_data2),
        .req_ready(req_ready2), .full(1'b0), .w_en(w_en2), .data_in(data_in2),
        .grant_id(grant_id2), .busy(busy2), .stat_clr(1'b0), .stat_cnt(stat_cnt2)
    );

    typedef struct packed {
        logic [N-1:0]    rdy;
        logic            wen;
        logic            busy;
        logic [N*16-1:0] stat;
    } cyc_t;

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] data;
    } beat_t;

    cyc_t  cycq[$];
    beat_t beatq[$];
    cyc_t  mon_c;
    beat_t mon_b;

    int total = 0;
    int bad   = 0;

    // Reference model state: who holds the port, how many beats it has used, where the search starts.
    bit m_locked;
    int m_owner;
    int m_used;
    int m_ptr;
    int m_stat[N];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_used   = 0;
        m_ptr    = 0;
        for (int i = 0; i < N; i++) m_stat[i] = 0;
    endtask

    // Drives one cycle of inputs, predicts that cycle's response, then advances to just after the edge.
    task automatic applyStimulus(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                                 input logic f, input logic clr);
        int           xid;
        int           i;
        logic [N-1:0] rdy;
        cyc_t         c;
        beat_t        b;
        req_valid = v;
        req_data  = d;
        full      = f;
        stat_clr  = clr;
        xid = -1;
        rdy = '0;
        if (!m_locked) begin
            for (int k = 0; k < N; k++) begin
                i = (m_ptr + k) % N;
                if (xid < 0 && v[i] && !f) xid = i;
            end
            if (xid >= 0) rdy[xid] = 1'b1;
        end else begin
            if (!f) rdy[m_owner] = 1'b1;
            if (!f && v[m_owner]) xid = m_owner;
        end
        c.rdy  = rdy;
        c.wen  = (xid >= 0);
        c.busy = m_locked;
        c.stat = '0;
        for (int j = 0; j < N; j++) c.stat[j*16 +: 16] = 16'(m_stat[j]);
        cycq.push_back(c);
        if (xid >= 0) begin
            b.id   = 2'(xid);
            b.data = d[xid*DW +: DW];
            beatq.push_back(b);
        end
        if (!m_locked) begin
            if (xid >= 0) begin
                if (BL == 1) begin
                    m_ptr = (xid + 1) % N;
                end else begin
                    m_locked = 1'b1;
                    m_owner  = xid;
                    m_used   = 1;
                end
            end
        end else if (!v[m_owner]) begin
            m_locked = 1'b0;
            m_ptr    = (m_owner + 1) % N;
        end else if (xid >= 0) begin
            m_used++;
            if (m_used == BL) begin
                m_locked = 1'b0;
                m_ptr    = (m_owner + 1) % N;
            end
        end
`ifdef FIFO_ARB_STATS_EN
        for (int j = 0; j < N; j++) begin
            if (clr) m_stat[j] = 0;
            else if (j == xid && m_stat[j] < 65535) m_stat[j]++;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    // Monitor: per-cycle handshake/status expectations, and beat contents whenever w_en is seen.
    always @(negedge clk) begin
        if (cycq.size() > 0) begin
            mon_c = cycq.pop_front();
            checkOutput("req_ready", 64'(req_ready), 64'(mon_c.rdy));
            checkOutput("w_en", 64'(w_en), 64'(mon_c.wen));
            checkOutput("busy", 64'(busy), 64'(mon_c.busy));
            checkOutput("stat_cnt", 64'(stat_cnt), 64'(mon_c.stat));
            if (w_en) begin
                if (beatq.size() == 0) begin
                    checkOutput("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    mon_b = beatq.pop_front();
                    checkOutput("grant_id", 64'(grant_id), 64'(mon_b.id));
                    checkOutput("data_in", 64'(data_in), 64'(mon_b.data));
                end
            end
        end
    end

    // The 3-requester per-beat instance must serve 0,1,2,0,... every cycle from reset.
    int exp3 = 0;
    logic [7:0] exp3_data;
    always @(negedge clk) begin
        if (wrst) begin
            exp3 = 0;
        end else begin
            exp3_data = req_data2[exp3*8 +: 8];
            checkOutput("rr3_grant", 64'(grant_id2), 64'(exp3));
            checkOutput("rr3_w_en", 64'(w_en2), 64'd1);
            checkOutput("rr3_data", 64'(data_in2), 64'(exp3_data));
            exp3 = (exp3 == 2) ? 0 : exp3 + 1;
        end
    end

    function automatic logic [N*DW-1:0] rndData();
        return {$urandom, $urandom} [N*DW-1:0];
    endfunction

    initial begin
        logic [N*DW-1:0] d;
        modelReset();
        wrst      = 1'b1;
        req_valid = '1;
        req_data  = 32'h44_33_22_11;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
        checkOutput("rst_w_en", 64'(w_en), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_grant_id", 64'(grant_id), 64'd0);
        checkOutput("rst_data_in", 64'(data_in), 64'd0);
        checkOutput("rst_stat_cnt", 64'(stat_cnt), 64'd0);
        wrst = 1'b0;

        for (int n = 0; n < 24; n++) applyStimulus('1, rndData(), 1'b0, 1'b0);

        // Owner drops valid after two beats; the next requester follows one bubble later.
        applyStimulus('0, rndData(), 1'b0, 1'b0);
        applyStimulus(4'b0100, rndData(), 1'b0, 1'b0);
        applyStimulus(4'b0100, rndData(), 1'b0, 1'b0);
        for (int n = 0; n < 6; n++) applyStimulus(4'b1000, rndData(), 1'b0, 1'b0);

        // Full stalls a half-finished burst from requester 1.
        applyStimulus('0, rndData(), 1'b0, 1'b0);
        d = rndData();
        applyStimulus(4'b0010, d, 1'b0, 1'b0);
        applyStimulus(4'b0010, d, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++) applyStimulus('1, d, 1'b1, 1'b0);
        for (int n = 0; n < 6; n++) applyStimulus('1, rndData(), 1'b0, 1'b0);

        // Statistics: clear, ten beats from requester 1, then clear alongside a beat.
        applyStimulus('0, rndData(), 1'b0, 1'b1);
        for (int n = 0; n < 10; n++) applyStimulus(4'b0010, rndData(), 1'b0, 1'b0);
        applyStimulus(4'b0010, rndData(), 1'b0, 1'b1);
        applyStimulus('0, rndData(), 1'b0, 1'b0);
        applyStimulus('0, rndData(), 1'b0, 1'b0);

        for (int n = 0; n < 300; n++)
            applyStimulus(N'($urandom), rndData(), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 19) == 0));

        // Reset in the middle of a burst owned by requester 2.
        for (int n = 0; n < 60 && !(m_locked && m_owner == 2); n++)
            applyStimulus('1, rndData(), 1'b0, 1'b0);
        checkOutput("owner2_reached", 64'(m_locked && m_owner == 2), 64'd1);
        wrst = 1'b1;
        #1;
        checkOutput("midrst_req_ready", 64'(req_ready), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_w_en", 64'(w_en), 64'd0);
        @(posedge clk);
        #1;
        wrst = 1'b0;
        modelReset();
        for (int n = 0; n < 8; n++) applyStimulus('1, rndData(), 1'b0, 1'b0);

        for (int n = 0; n < 200; n++)
            applyStimulus(N'($urandom), rndData(), ($urandom_range(0, 4) == 0), 1'b0);

        @(negedge clk);
        #1;
        checkOutput("beatq_drained", 64'(beatq.size()), 64'd0);
        checkOutput("cycq_drained", 64'(cycq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
